// File: rtl/regfile_param_pkg.sv
// Shared definitions for the parametrised register file: sp_op encodings,
// default geometry and the named register indices.
package regfile_param_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_NUM_REGS = 8;

    // Stack-pointer operation requested on sp_op
    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10,
        SP_RSVD = 2'b11
    } sp_op_e;

    // Register indices at the default geometry
    localparam int unsigned REG_AX = 0;
    localparam int unsigned REG_BX = 1;
    localparam int unsigned REG_CX = 2;
    localparam int unsigned REG_DX = 3;
    localparam int unsigned REG_SP = 4;
    localparam int unsigned REG_BP = 5;
    localparam int unsigned REG_DI = 6;
    localparam int unsigned REG_SI = 7;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: decodes the read index against the next-state
// register image (write-first), registers the result and raises a one-cycle valid.
module regfile_read_port
    import regfile_param_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned AW       = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      re,
    input  logic [AW-1:0]             raddr,
    input  logic [NUM_REGS*WIDTH-1:0] next_flat,
    output logic [WIDTH-1:0]          rdata,
    output logic                      rvalid
);

    logic [WIDTH-1:0] sel;

    // Index decode; an index past the last register reads as zero
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (raddr == AW'(i)) begin
                sel = next_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= en && re;
            if (en && re) begin
                rdata <= sel;
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised general-purpose register file with two registered read ports,
// write-first forwarding and a stack-pointer increment/decrement path.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEF_WIDTH,
    parameter int unsigned      NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned      SP_INDEX = REG_SP,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(16'hFFFE),
    localparam int unsigned     AW       = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re1,
    input  logic [AW-1:0]             raddr1,
    input  logic                      re2,
    input  logic [AW-1:0]             raddr2,
    output logic [WIDTH-1:0]          rdata1,
    output logic [WIDTH-1:0]          rdata2,
    output logic                      rvalid1,
    output logic                      rvalid2,
    input  logic [1:0]                sp_op,
    output logic [WIDTH-1:0]          sp_out,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat
);

    logic [WIDTH-1:0]          mem_q [NUM_REGS];
    logic [WIDTH-1:0]          mem_d [NUM_REGS];
    logic [NUM_REGS*WIDTH-1:0] next_flat;
    logic                      wr_ok;
    logic                      wr_sp;

    assign wr_ok = we && (32'(waddr) < NUM_REGS);
    assign wr_sp = wr_ok && (waddr == AW'(SP_INDEX));

    // Next-state image: explicit write beats the SP op on the SP register
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            if (wr_ok) begin
                mem_d[waddr] = wdata;
            end
            if (!wr_sp) begin
                unique case (sp_op_e'(sp_op))
                    SP_PUSH: mem_d[SP_INDEX] = mem_q[SP_INDEX] - WIDTH'(1);
                    SP_POP:  mem_d[SP_INDEX] = mem_q[SP_INDEX] + WIDTH'(1);
                    default: ;
                endcase
            end
        end
    end

    // Register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= (i == int'(SP_INDEX)) ? SP_RESET : '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Flatten current and next-state images
    always_comb begin
        regs_flat = '0;
        next_flat = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_flat[i*WIDTH +: WIDTH] = mem_q[i];
            next_flat[i*WIDTH +: WIDTH] = mem_d[i];
        end
    end

    assign sp_out = mem_q[SP_INDEX];

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_rd1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .re        (re1),
        .raddr     (raddr1),
        .next_flat (next_flat),
        .rdata     (rdata1),
        .rvalid    (rvalid1)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_rd2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .re        (re2),
        .raddr     (raddr2),
        .next_flat (next_flat),
        .rdata     (rdata2),
        .rvalid    (rvalid2)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default 8x16 build plus an 8-bit,
// 6-register build for the out-of-range address cases.
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default build
    logic         en = 0, we = 0, re1 = 0, re2 = 0;
    logic [2:0]   waddr = 0, raddr1 = 0, raddr2 = 0;
    logic [15:0]  wdata = 0;
    logic [1:0]   sp_op = 0;
    logic [15:0]  rdata1, rdata2, sp_out;
    logic         rvalid1, rvalid2;
    logic [127:0] regs_flat;

    regfile_param dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .rvalid1(rvalid1), .rvalid2(rvalid2),
        .sp_op(sp_op), .sp_out(sp_out), .regs_flat(regs_flat)
    );

    // WIDTH=8, NUM_REGS=6 build
    logic        en_b = 0, we_b = 0, re1_b = 0, re2_b = 0;
    logic [2:0]  waddr_b = 0, raddr1_b = 0, raddr2_b = 0;
    logic [7:0]  wdata_b = 0;
    logic [1:0]  sp_op_b = 0;
    logic [7:0]  rdata1_b, rdata2_b, sp_out_b;
    logic        rvalid1_b, rvalid2_b;
    logic [47:0] regs_flat_b;

    regfile_param #(.WIDTH(8), .NUM_REGS(6), .SP_INDEX(4), .SP_RESET(8'hFE)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .re1(re1_b), .raddr1(raddr1_b), .re2(re2_b), .raddr2(raddr2_b),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .rvalid1(rvalid1_b), .rvalid2(rvalid2_b),
        .sp_op(sp_op_b), .sp_out(sp_out_b), .regs_flat(regs_flat_b)
    );

    // Reference model of the default build
    logic [15:0] m_regs [8];
    logic [15:0] m_rd1, m_rd2;
    logic        m_rv1, m_rv2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 16'h0000;
        m_regs[4] = 16'hFFFE;
        m_rd1 = 0; m_rd2 = 0; m_rv1 = 0; m_rv2 = 0;
    endtask

    // Apply one clock edge to the model using the current inputs
    task automatic model_edge();
        logic [15:0] nxt [8];
        nxt = m_regs;
        m_rv1 = 0;
        m_rv2 = 0;
        if (en) begin
            if (sp_op == 2'd1) nxt[4] = m_regs[4] - 16'd1;
            if (sp_op == 2'd2) nxt[4] = m_regs[4] + 16'd1;
            if (we) nxt[waddr] = wdata;
            m_rv1 = re1;
            m_rv2 = re2;
            if (re1) m_rd1 = nxt[raddr1];
            if (re2) m_rd2 = nxt[raddr2];
            m_regs = nxt;
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f = '0;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_regs[i];
        return f;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".regs"},    regs_flat, model_flat());
        check({tag, ".sp"},      sp_out,    m_regs[4]);
        check({tag, ".rdata1"},  rdata1,    m_rd1);
        check({tag, ".rvalid1"}, rvalid1,   m_rv1);
        check({tag, ".rdata2"},  rdata2,    m_rd2);
        check({tag, ".rvalid2"}, rvalid2,   m_rv2);
    endtask

    // Inputs are already set (after a negedge); clock one edge and compare at the next negedge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    typedef struct {
        logic        en, we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        re1;
        logic [2:0]  raddr1;
        logic        re2;
        logic [2:0]  raddr2;
        logic [1:0]  sp_op;
        logic [15:0] e_rd1;
        logic        e_rv1;
        logic [15:0] e_rd2;
        logic        e_rv2;
        logic [15:0] e_sp;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // Directed table: en we wa wdata re1 ra1 re2 ra2 sp | rd1 rv1 rd2 rv2 sp
        vecs[0]  = '{1, 1, 0, 16'h000F, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFE};
        vecs[1]  = '{1, 1, 1, 16'h00FF, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFE};
        vecs[2]  = '{1, 1, 2, 16'h0FFF, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFE};
        vecs[3]  = '{1, 1, 3, 16'hFFFF, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFE};
        vecs[4]  = '{1, 0, 0, 16'h0000, 1, 0, 1, 3, 0, 16'h000F, 1, 16'hFFFF, 1, 16'hFFFE};
        vecs[5]  = '{1, 0, 0, 16'h0000, 1, 1, 1, 2, 0, 16'h00FF, 1, 16'h0FFF, 1, 16'hFFFE};
        vecs[6]  = '{1, 0, 0, 16'h0000, 1, 2, 1, 1, 0, 16'h0FFF, 1, 16'h00FF, 1, 16'hFFFE};
        vecs[7]  = '{1, 0, 0, 16'h0000, 1, 3, 1, 0, 0, 16'hFFFF, 1, 16'h000F, 1, 16'hFFFE};
        vecs[8]  = '{1, 1, 2, 16'hA5A5, 1, 2, 1, 2, 0, 16'hA5A5, 1, 16'hA5A5, 1, 16'hFFFE};
        vecs[9]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'hA5A5, 0, 16'hA5A5, 0, 16'hFFFD};
        vecs[10] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'hA5A5, 0, 16'hA5A5, 0, 16'hFFFC};
        vecs[11] = '{1, 0, 0, 16'h0000, 1, 4, 0, 0, 1, 16'hFFFB, 1, 16'hA5A5, 0, 16'hFFFB};
        vecs[12] = '{1, 1, 4, 16'h0000, 0, 0, 1, 4, 2, 16'hFFFB, 0, 16'h0000, 1, 16'h0000};
        vecs[13] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'hFFFB, 0, 16'h0000, 0, 16'hFFFF};
        vecs[14] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 2, 16'hFFFB, 0, 16'h0000, 0, 16'h0000};
        vecs[15] = '{0, 1, 0, 16'hBEEF, 1, 0, 0, 0, 1, 16'hFFFB, 0, 16'h0000, 0, 16'h0000};
        vecs[16] = '{1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h000F, 1, 16'h0000, 0, 16'h0000};

        model_reset();
        @(negedge clk);
        check("reset.regs", regs_flat, model_flat());
        check("reset.sp", sp_out, 16'hFFFE);
        @(negedge clk);
        rst = 1'b0;

        // Put some state in, then reset in the middle of a write
        en = 1; we = 1; waddr = 1; wdata = 16'h5555; re1 = 1; raddr1 = 1;
        step("prewrite");
        we = 1; waddr = 0; wdata = 16'h1234; re1 = 1; raddr1 = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("midrst.regs", regs_flat, 128'h0000_0000_0000_FFFE_0000_0000_0000_0000);
        check("midrst.rdata1", rdata1, 16'h0000);
        check("midrst.rvalid1", rvalid1, 1'b0);
        check("midrst.sp", sp_out, 16'hFFFE);
        @(negedge clk);
        rst = 1'b0; we = 0; re1 = 0;
        step("postrst");

        // Directed table
        for (int i = 0; i < 17; i++) begin
            en = vecs[i].en; we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re1 = vecs[i].re1; raddr1 = vecs[i].raddr1;
            re2 = vecs[i].re2; raddr2 = vecs[i].raddr2; sp_op = vecs[i].sp_op;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.rdata1", i), rdata1, vecs[i].e_rd1);
            check($sformatf("vec%0d.rvalid1", i), rvalid1, vecs[i].e_rv1);
            check($sformatf("vec%0d.rdata2", i), rdata2, vecs[i].e_rd2);
            check($sformatf("vec%0d.rvalid2", i), rvalid2, vecs[i].e_rv2);
            check($sformatf("vec%0d.sp", i), sp_out, vecs[i].e_sp);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            we = $urandom_range(0, 1);
            waddr = 3'($urandom_range(0, 7));
            wdata = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            re1 = $urandom_range(0, 1); raddr1 = 3'($urandom_range(0, 7));
            re2 = $urandom_range(0, 1); raddr2 = 3'($urandom_range(0, 7));
            sp_op = 2'($urandom_range(0, 3));
            step("rand");
        end
        en = 0; we = 0; re1 = 0; re2 = 0; sp_op = 0;

        // 8-bit, 6-register build: out-of-range write and read
        en_b = 1; we_b = 1; waddr_b = 7; wdata_b = 8'hAA;
        @(negedge clk);
        check("b.oor_write", regs_flat_b, 48'h00FE_0000_0000);
        waddr_b = 5; wdata_b = 8'h3C;
        @(negedge clk);
        check("b.write5", regs_flat_b, 48'h3CFE_0000_0000);
        we_b = 0; re1_b = 1; raddr1_b = 6; re2_b = 1; raddr2_b = 5; sp_op_b = 2'd1;
        @(negedge clk);
        check("b.oor_rdata", rdata1_b, 8'h00);
        check("b.oor_rvalid", rvalid1_b, 1'b1);
        check("b.rdata2", rdata2_b, 8'h3C);
        check("b.rvalid2", rvalid2_b, 1'b1);
        check("b.sp_push", sp_out_b, 8'hFD);
        re1_b = 0; re2_b = 0; sp_op_b = 0;
        @(negedge clk);
        check("b.rvalid_drop", rvalid1_b, 1'b0);
        check("b.rdata_hold", rdata2_b, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
